// File: rtl/overture_branch_sequencer_if.sv
// Decoder-to-sequencer instruction handshake bundle.
// Master = decoder, slave = branch sequencer.
interface overture_branch_sequencer_if #(
   parameter int PC_WIDTH   = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  instr_valid;
   logic                  instr_ready;
   logic                  is_cond;
   logic                  is_call;
   logic                  is_ret;
   logic [2:0]            cond_code;
   logic [DATA_WIDTH-1:0] cond_value;
   logic [PC_WIDTH-1:0]   jump_target;

   modport master (
      output instr_valid,
      output is_cond,
      output is_call,
      output is_ret,
      output cond_code,
      output cond_value,
      output jump_target,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  is_cond,
      input  is_call,
      input  is_ret,
      input  cond_code,
      input  cond_value,
      input  jump_target,
      output instr_ready
   );
endinterface

// File: rtl/overture_branch_sequencer.sv
// OVERTURE branch sequencer: condition eval, PC, RUN/FLUSH/HALT.
// Optional return stack: define OVERTURE_CALL_STACK_EN.
module overture_branch_sequencer #(
   parameter int PC_WIDTH    = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   overture_branch_sequencer_if.slave dec,
   input  logic                halt,
   input  logic                resume,
   output logic [PC_WIDTH-1:0] pc,
   output logic                fetch_en,
   output logic                branch_taken,
   output logic                flush,
   output logic                stack_err
);

   typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

   state_t              state, state_n;
   logic [PC_WIDTH-1:0] pc_n, pc_inc, jump_pc;
   logic                bt_n, fl_n, hold, hold_n;
   logic                accept, zero, neg;
   logic                cond_true, take, jump;

   assign dec.instr_ready = (state == RUN);
   assign accept   = dec.instr_valid & dec.instr_ready;
   assign fetch_en = (state != HALT);
   assign zero     = (dec.cond_value == '0);
   assign neg      = dec.cond_value[DATA_WIDTH-1];
   assign pc_inc   = pc + PC_WIDTH'(1);
   assign take     = dec.is_cond & cond_true;

   // Decode the 3-bit condition code against zero/sign flags.
   always_comb begin
      cond_true = 1'b0;
      unique case (dec.cond_code)
         3'd0: cond_true = 1'b0;
         3'd1: cond_true = zero;
         3'd2: cond_true = neg;
         3'd3: cond_true = neg | zero;
         3'd4: cond_true = 1'b1;
         3'd5: cond_true = ~zero;
         3'd6: cond_true = ~neg;
         3'd7: cond_true = ~neg & ~zero;
         default: cond_true = 1'b0;
      endcase
   end

`ifdef OVERTURE_CALL_STACK_EN
   localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int CW = $clog2(STACK_DEPTH + 1);
   localparam logic [PW-1:0] PTR_MAX = PW'(STACK_DEPTH - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STACK_DEPTH);

   logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
   logic [PW-1:0]       ptr, ptr_inc, ptr_dec;
   logic [CW-1:0]       cnt;
   logic                err, do_push, do_pop;

   assign ptr_inc   = (ptr == PTR_MAX) ? '0 : ptr + PW'(1);
   assign ptr_dec   = (ptr == '0) ? PTR_MAX : ptr - PW'(1);
   assign do_push   = accept & dec.is_call & take;
   assign do_pop    = accept & dec.is_ret & ~dec.is_call;
   assign jump      = take | do_pop;
   assign jump_pc   = do_pop ? stack[ptr_dec] : dec.jump_target;
   assign stack_err = err;

   // Return-address storage; ptr is the next free slot.
   always_ff @(posedge clk) begin
      if (do_push) stack[ptr] <= pc_inc;
   end

   // Pointer, fill count and sticky over/underflow flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr <= '0;
         cnt <= '0;
         err <= 1'b0;
      end else if (do_push) begin
         ptr <= ptr_inc;
         if (cnt == CNT_MAX) err <= 1'b1;
         else                cnt <= cnt + CW'(1);
      end else if (do_pop) begin
         ptr <= ptr_dec;
         if (cnt == '0) err <= 1'b1;
         else           cnt <= cnt - CW'(1);
      end
   end
`else
   logic unused_ok;

   assign jump      = take;
   assign jump_pc   = dec.jump_target;
   assign stack_err = 1'b0;
   assign unused_ok = ^{dec.is_call, dec.is_ret, 1'(STACK_DEPTH)};
`endif

   // Next-state, next-PC and pulse outputs.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      bt_n    = 1'b0;
      fl_n    = 1'b0;
      hold_n  = hold;
      unique case (state)
         RUN: begin
            if (accept) begin
               if (jump) begin
                  pc_n    = jump_pc;
                  bt_n    = 1'b1;
                  fl_n    = 1'b1;
                  hold_n  = halt;
                  state_n = FLUSH;
               end else begin
                  pc_n = pc_inc;
                  if (halt) state_n = HALT;
               end
            end else if (halt) begin
               state_n = HALT;
            end
         end
         FLUSH: begin
            hold_n  = 1'b0;
            state_n = (halt | hold) ? HALT : RUN;
         end
         HALT: begin
            if (resume & ~halt) state_n = RUN;
         end
         default: state_n = RUN;
      endcase
   end

   // State and PC registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= RUN;
         pc           <= '0;
         branch_taken <= 1'b0;
         flush        <= 1'b0;
         hold         <= 1'b0;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         branch_taken <= bt_n;
         flush        <= fl_n;
         hold         <= hold_n;
      end
   end

endmodule

// File: doc/overture_branch_sequencer.md
Name: overture_branch_sequencer

Overview:
- Consumer end of the OVERTURE condition path. It evaluates the 3-bit condition field against the condition register value and owns the program counter.
- On a true condition it loads the PC from the jump-target register. Otherwise it increments the PC.
- It runs a small RUN/FLUSH/HALT state machine, so the one instruction already fetched behind a taken branch is discarded.
- Sits between the instruction decoder and program memory address port.

Parameters:
- PC_WIDTH, 8, program counter / jump target width.
- DATA_WIDTH, 8, condition value width; bit DATA_WIDTH-1 is the sign bit.
- STACK_DEPTH, 4, return-stack entries (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rise).
- instr_valid  in  1  decoder presents an instruction this cycle.
- instr_ready  out  1  sequencer accepts the instruction (handshake = valid & ready).
- is_cond  in  1  accepted instruction is a condition/branch op.
- cond_code  in  3  0 never, 1 ==0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0.
- cond_value  in  DATA_WIDTH  condition register value, signed two's complement.
- jump_target  in  PC_WIDTH  jump-target register value.
- halt  in  1  request stop after the current instruction.
- resume  in  1  leave HALT.
- pc  out  PC_WIDTH  current fetch address.
- fetch_en  out  1  program memory read enable.
- branch_taken  out  1  one-cycle registered pulse, branch resolved true.
- flush  out  1  discard the instruction currently in the decode latch.
- is_call / is_ret  in  1 each  optional-feature ports; ignored when the feature is compiled out.
- stack_err  out  1  optional-feature port; 0 when the feature is compiled out.

Behaviour:
- Reset (rst=0 at clk edge):
  - state=RUN, pc=0.
  - branch_taken=0, flush=0, stack_err=0.
  - fetch_en=1 from the first cycle after rst releases.
  - Reset overrides everything, including mid-FLUSH and mid-HALT.
- instr_ready = (state==RUN). instr_valid while not ready is held by the decoder, not dropped.
- Condition evaluation is combinational on the accept cycle:
  - zero = (cond_value==0), neg = cond_value[DATA_WIDTH-1].
  - The selected code yields take = is_cond & cond(code).
- RUN, on accept:
  - take=1: pc<=jump_target, branch_taken<=1, flush<=1, state<=FLUSH.
  - take=0: pc<=pc+1, wrapping from 2^PC_WIDTH-1 to 0.
- RUN, no accept: pc holds.
- FLUSH, exactly one cycle:
  - instr_ready=0, flush=1, the fetch from the new pc proceeds.
  - Next state RUN, or HALT if halt is sampled high.
  - branch_taken and flush are each high exactly one cycle.
- halt:
  - Sampled in RUN on an accept cycle: that instruction completes (pc updates as above), then state<=HALT. A taken branch with halt still passes through FLUSH first.
  - halt in RUN with no accept: state<=HALT immediately.
- HALT: fetch_en=0, instr_ready=0, pc holds. resume=1 -> RUN next cycle.
- halt and resume both high: halt wins.
- Branch to the current pc (self-loop) is legal and still flushes.
- cond_code 0 never takes; 4 always takes, independent of cond_value.

Optional Feature:
- Macro: OVERTURE_CALL_STACK_EN.
- Enabled: a STACK_DEPTH x PC_WIDTH LIFO with a pointer.
  - Accepted is_call with take=1 pushes pc+1 and jumps.
  - Accepted is_ret pops into pc, with branch_taken and flush as for a branch.
  - Push when full or pop when empty: stack_err is sticky until reset, the pointer wraps modulo STACK_DEPTH, and the jump/return still executes.
  - is_call and is_ret both high: is_ret ignored.
- Disabled: is_call is treated as a plain branch, is_ret is ignored, stack_err is tied 0, and no stack storage is built.

Test Plan:
- Reset, then 5 accepts with is_cond=0 -> pc 0,1,2,3,4,5; branch_taken never high.
- pc=7, is_cond=1, code=2, cond_value=8'h80, jump_target=8'h40 -> pc=8'h40 next cycle; branch_taken and flush each high 1 cycle; instr_ready low 1 cycle.
- code=2 with cond_value=8'h00 -> not taken, pc+1. code=7 with 8'h01 -> taken. code=3 with 8'h00 -> taken. code=0 with any value -> never taken.
- pc=8'hFF with a non-branch accept -> pc=8'h00, no error.
- halt asserted with a taken branch at pc=3, target 8'h10 -> FLUSH, then HALT with pc=8'h10 and fetch_en=0; resume -> RUN, fetching from 8'h10.
- OVERTURE_CALL_STACK_EN: five nested calls with STACK_DEPTH=4 -> stack_err=1 after the 5th call. Ret from an empty stack after reset -> stack_err=1. rst=0 mid-FLUSH -> pc=0, state RUN, stack_err=0.
